// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the default operand width.
package serial_add_defs;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake bundle between a requester (master) and the
// bit-serial adder controller (slave).
interface serial_add_ctrl_if
   import serial_add_defs::*;
   #(parameter int WIDTH = DEFAULT_WIDTH);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/full_adder.sv
// Existing single-bit full adder cell reused once per bit slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: walks one full_adder cell across WIDTH
// clock cycles, LSB first, holding the carry in a register between
// slices. The requester sees a start/busy/done handshake and a registered
// sum/cout that only changes when an add completes.
module serial_add_ctrl
   import serial_add_defs::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
(
   input  logic             clk,
   input  logic             rst,
   serial_add_ctrl_if.slave bus
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_stateNext;

   logic [WIDTH-1:0] r_aSh;
   logic [WIDTH-1:0] r_bSh;
   // Only the upper WIDTH-1 bits of the partial result need storage: the
   // bit that would drop out of the bottom is always a stale slice.
   logic [WIDTH-2:0] r_rHi;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_faSum;
   logic             w_faCout;
   logic [WIDTH-1:0] w_rNext;
   logic             w_lastSlice;

   // The single shared 1-bit adder works on the current LSBs and the held carry.
   full_adder fa0 (
      .a    (r_aSh[0]),
      .b    (r_bSh[0]),
      .cin  (r_carry),
      .sum  (w_faSum),
      .cout (w_faCout)
   );

   assign w_rNext     = {w_faSum, r_rHi};
   assign w_lastSlice = (r_cnt == LAST_CNT);

   assign bus.busy = (r_state == S_RUN);
   assign bus.done = (r_state == S_DONE);
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;

   // State register; reset aborts any add in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state decode: accept in IDLE, run WIDTH slices, one DONE cycle.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE:  if (bus.start)  w_stateNext = S_RUN;
         S_RUN:   if (w_lastSlice) w_stateNext = S_DONE;
         S_DONE:  w_stateNext = S_IDLE;
         default: w_stateNext = S_IDLE;
      endcase
   end

   // Datapath: capture operands on accept, shift one slice per RUN cycle,
   // and publish sum/cout only on the final slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_aSh   <= '0;
         r_bSh   <= '0;
         r_rHi   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_aSh   <= bus.a;
                  r_bSh   <= bus.b;
                  r_carry <= bus.cin;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_aSh   <= {1'b0, r_aSh[WIDTH-1:1]};
               r_bSh   <= {1'b0, r_bSh[WIDTH-1:1]};
               r_rHi   <= w_rNext[WIDTH-1:1];
               r_carry <= w_faCout;
               r_cnt   <= r_cnt + 1'b1;
               if (w_lastSlice) begin
                  r_sum  <= w_rNext;
                  r_cout <= w_faCout;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
